// File: rtl/irom_arb_pkg.sv
// irom_arb_pkg: shared constants and types for the instruction-ROM arbiter and the ROM.
package irom_arb_pkg;

    // Default geometry, shared with irom.
    localparam int unsigned IROM_ADDR_W = 24;
    localparam int unsigned IROM_DATA_W = 32;

    // Width of the port B starvation counter (MAX_WAIT is 0..15).
    localparam int unsigned WAIT_W = 4;

    // Which port owns the ROM data arriving this cycle.
    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_A    = 2'd1,
        RESP_B    = 2'd2
    } resp_e;

endpackage

// File: rtl/irom_arb.sv
// irom_arb: shares the single-port instruction ROM between the fetch port (A) and a
// secondary read port (B). Fetch has priority; B gets a bounded wait of MAX_WAIT cycles.
// ROM data arrives one cycle after the strobe and is routed to the port that issued it.
module irom_arb
    import irom_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = IROM_ADDR_W,
    parameter int unsigned DATA_W   = IROM_DATA_W,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              CLK,
    input  logic              RST_N,

    input  logic              A_REQ,
    input  logic [ADDR_W-1:0] A_ADDR,
    output logic              A_GNT,
    output logic              A_RVALID,
    output logic [DATA_W-1:0] A_RDATA,

    input  logic              B_REQ,
    input  logic [ADDR_W-1:0] B_ADDR,
    output logic              B_GNT,
    output logic              B_RVALID,
    output logic [DATA_W-1:0] B_RDATA,

    output logic [ADDR_W-1:0] ROM_ADDR,
    output logic              ROM_CS,
    input  logic [DATA_W-1:0] ROM_DOUT
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = MAX_WAIT[WAIT_W-1:0];

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    resp_e             resp_sel_q, resp_sel_d;
    logic [DATA_W-1:0] hold_a_q, hold_a_d;
    logic [DATA_W-1:0] hold_b_q, hold_b_d;
    logic              b_pri;
    logic              a_gnt, b_gnt;

    // Grant decision and ROM drive; everything is held off while reset is asserted.
    always_comb begin
        b_pri    = (wait_cnt_q >= MAX_WAIT_C);
        b_gnt    = RST_N & B_REQ & (~A_REQ | b_pri);
        a_gnt    = RST_N & A_REQ & ~b_gnt;
        A_GNT    = a_gnt;
        B_GNT    = b_gnt;
        ROM_CS   = a_gnt | b_gnt;
        ROM_ADDR = '0;
        if (RST_N) begin
            ROM_ADDR = b_gnt ? B_ADDR : A_ADDR;
        end
    end

    // Next state: starvation counter, response owner, per-port held data.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (b_gnt) begin
            wait_cnt_d = '0;
        end else if (B_REQ && (wait_cnt_q < MAX_WAIT_C)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        resp_sel_d = RESP_NONE;
        if (a_gnt) begin
            resp_sel_d = RESP_A;
        end else if (b_gnt) begin
            resp_sel_d = RESP_B;
        end

        hold_a_d = (resp_sel_q == RESP_A) ? ROM_DOUT : hold_a_q;
        hold_b_d = (resp_sel_q == RESP_B) ? ROM_DOUT : hold_b_q;
    end

    // State registers; an access in flight when reset asserts is dropped.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wait_cnt_q <= '0;
            resp_sel_q <= RESP_NONE;
            hold_a_q   <= '0;
            hold_b_q   <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            resp_sel_q <= resp_sel_d;
            hold_a_q   <= hold_a_d;
            hold_b_q   <= hold_b_d;
        end
    end

    // Read data: live ROM output in the response cycle, otherwise the port's own held copy.
    always_comb begin
        A_RVALID = (resp_sel_q == RESP_A);
        B_RVALID = (resp_sel_q == RESP_B);
        A_RDATA  = A_RVALID ? ROM_DOUT : hold_a_q;
        B_RDATA  = B_RVALID ? ROM_DOUT : hold_b_q;
    end

endmodule

// File: tb/tb_irom_arb.sv
// tb_irom_arb: directed bench for irom_arb with a behavioural ROM (word[i] = C0DE0000 + i)
// and a cycle-level reference model checked on every falling edge.
module tb_irom_arb;

    localparam int unsigned ADDR_W   = 24;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MAX_WAIT = 4;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b1;
    logic              A_REQ = 1'b0;
    logic [ADDR_W-1:0] A_ADDR = '0;
    logic              A_GNT, A_RVALID;
    logic [DATA_W-1:0] A_RDATA;
    logic              B_REQ = 1'b0;
    logic [ADDR_W-1:0] B_ADDR = '0;
    logic              B_GNT, B_RVALID;
    logic [DATA_W-1:0] B_RDATA;
    logic [ADDR_W-1:0] ROM_ADDR;
    logic              ROM_CS;
    logic [DATA_W-1:0] ROM_DOUT = '0;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    irom_arb #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .A_REQ   (A_REQ),
        .A_ADDR  (A_ADDR),
        .A_GNT   (A_GNT),
        .A_RVALID(A_RVALID),
        .A_RDATA (A_RDATA),
        .B_REQ   (B_REQ),
        .B_ADDR  (B_ADDR),
        .B_GNT   (B_GNT),
        .B_RVALID(B_RVALID),
        .B_RDATA (B_RDATA),
        .ROM_ADDR(ROM_ADDR),
        .ROM_CS  (ROM_CS),
        .ROM_DOUT(ROM_DOUT)
    );

    // Behavioural ROM with registered output.
    always @(posedge CLK) begin
        if (ROM_CS) ROM_DOUT <= 32'hC0DE_0000 + 32'(ROM_ADDR);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: denied-cycle count for B, the in-flight access, each port's last data.
    int          m_wait = 0;
    bit          m_pa = 1'b0, m_pb = 1'b0;
    logic [31:0] m_pd = '0, m_ha = '0, m_hb = '0;
    bit          e_a, e_b;
    logic [31:0] e_addr;

    always @(negedge CLK) begin
        if (!RST_N) begin
            m_wait = 0; m_pa = 1'b0; m_pb = 1'b0; m_ha = '0; m_hb = '0;
            chk("m_rst_a_gnt", 32'(A_GNT), 32'd0);
            chk("m_rst_b_gnt", 32'(B_GNT), 32'd0);
            chk("m_rst_cs", 32'(ROM_CS), 32'd0);
            chk("m_rst_addr", 32'(ROM_ADDR), 32'd0);
            chk("m_rst_a_rvalid", 32'(A_RVALID), 32'd0);
            chk("m_rst_b_rvalid", 32'(B_RVALID), 32'd0);
            chk("m_rst_a_rdata", A_RDATA, 32'd0);
            chk("m_rst_b_rdata", B_RDATA, 32'd0);
        end else begin
            e_b    = B_REQ && (!A_REQ || m_wait >= MAX_WAIT);
            e_a    = A_REQ && !e_b;
            e_addr = 32'(e_b ? B_ADDR : A_ADDR);
            chk("m_a_gnt", 32'(A_GNT), 32'(e_a));
            chk("m_b_gnt", 32'(B_GNT), 32'(e_b));
            chk("m_cs", 32'(ROM_CS), 32'(e_a || e_b));
            chk("m_addr", 32'(ROM_ADDR), e_addr);
            chk("m_a_rvalid", 32'(A_RVALID), 32'(m_pa));
            chk("m_b_rvalid", 32'(B_RVALID), 32'(m_pb));
            chk("m_a_rdata", A_RDATA, m_pa ? m_pd : m_ha);
            chk("m_b_rdata", B_RDATA, m_pb ? m_pd : m_hb);
            if (m_pa) m_ha = m_pd;
            if (m_pb) m_hb = m_pd;
            m_pa = e_a;
            m_pb = e_b;
            m_pd = 32'hC0DE_0000 + e_addr;
            if (e_b) m_wait = 0;
            else if (B_REQ && m_wait < MAX_WAIT) m_wait = m_wait + 1;
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset with fetch requesting.
        #1;
        RST_N = 1'b0; A_REQ = 1'b1; A_ADDR = 24'd5;
        @(negedge CLK);
        chk("rst_a_gnt", 32'(A_GNT), 32'd0);
        chk("rst_cs", 32'(ROM_CS), 32'd0);
        chk("rst_a_rdata", A_RDATA, 32'd0);
        chk("rst_b_rdata", B_RDATA, 32'd0);
        next_cycle();

        // Release: grant in the same cycle, then a single fetch of address 5.
        RST_N = 1'b1;
        @(negedge CLK);
        chk("rel_a_gnt", 32'(A_GNT), 32'd1);
        next_cycle();
        A_REQ = 1'b0;
        @(negedge CLK);
        chk("fetch_rvalid", 32'(A_RVALID), 32'd1);
        chk("fetch_rdata", A_RDATA, 32'hC0DE_0005);
        next_cycle();
        @(negedge CLK);
        chk("fetch_rvalid_drop", 32'(A_RVALID), 32'd0);
        chk("fetch_hold", A_RDATA, 32'hC0DE_0005);
        next_cycle();

        // Back-to-back fetches 0..3.
        for (int k = 0; k <= 4; k++) begin
            A_REQ = (k < 4); A_ADDR = 24'(k);
            @(negedge CLK);
            if (k >= 1) begin
                chk("b2b_rvalid", 32'(A_RVALID), 32'd1);
                chk("b2b_rdata", A_RDATA, 32'hC0DE_0000 + 32'(k - 1));
            end
            next_cycle();
        end

        // Starvation bound: B granted in its fifth requesting cycle.
        for (int c = 0; c <= 5; c++) begin
            A_REQ = 1'b1; A_ADDR = 24'(16 + c);
            B_REQ = (c <= 4); B_ADDR = 24'd9;
            @(negedge CLK);
            chk("starve_b_gnt", 32'(B_GNT), 32'(c == 4));
            chk("starve_a_gnt", 32'(A_GNT), 32'(c != 4));
            if (c == 5) begin
                chk("starve_b_rvalid", 32'(B_RVALID), 32'd1);
                chk("starve_b_rdata", B_RDATA, 32'hC0DE_0009);
            end
            next_cycle();
        end
        A_REQ = 1'b0; B_REQ = 1'b0;
        next_cycle();

        // Isolation: A reads 7, then B reads 8.
        A_REQ = 1'b1; A_ADDR = 24'd7;
        next_cycle();
        A_REQ = 1'b0; B_REQ = 1'b1; B_ADDR = 24'd8;
        @(negedge CLK);
        chk("iso_b_gnt", 32'(B_GNT), 32'd1);
        chk("iso_a_rdata1", A_RDATA, 32'hC0DE_0007);
        next_cycle();
        B_REQ = 1'b0;
        @(negedge CLK);
        chk("iso_b_rdata", B_RDATA, 32'hC0DE_0008);
        chk("iso_a_rdata2", A_RDATA, 32'hC0DE_0007);
        next_cycle();
        @(negedge CLK);
        chk("iso_a_rdata3", A_RDATA, 32'hC0DE_0007);
        chk("iso_b_rdata3", B_RDATA, 32'hC0DE_0008);
        next_cycle();

        // Mid-access reset: B granted at 3, reset in the response cycle.
        B_REQ = 1'b1; B_ADDR = 24'd3;
        @(negedge CLK);
        chk("mid_b_gnt", 32'(B_GNT), 32'd1);
        next_cycle();
        B_REQ = 1'b0; RST_N = 1'b0;
        @(negedge CLK);
        chk("mid_b_rvalid", 32'(B_RVALID), 32'd0);
        chk("mid_b_rdata", B_RDATA, 32'd0);
        next_cycle();
        RST_N = 1'b1;
        next_cycle();

        // Wait count built up by denials must be cleared by reset.
        A_REQ = 1'b1; B_REQ = 1'b1; B_ADDR = 24'd2;
        for (int c = 0; c < 3; c++) next_cycle();
        RST_N = 1'b0;
        next_cycle();
        RST_N = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            A_ADDR = 24'(32 + c);
            @(negedge CLK);
            chk("rstcnt_b_gnt", 32'(B_GNT), 32'(c == 4));
            next_cycle();
        end
        A_REQ = 1'b0; B_REQ = 1'b0;
        next_cycle();
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irom_arb.md
# irom_arb

Two-port arbiter that shares the single-port instruction ROM between the Tawas core instruction-fetch port (port A) and a secondary read port (port B: data-side constant loads and debug/loader reads). It sits between the requesters and the ROM: it drives the ROM chip-select and address, and routes the one-cycle-late ROM data back to the port that issued the access. Fetch has priority, with a bounded-wait guarantee for port B. Each port has its own held read-data register.

## Interface
Parameters:
- ADDR_W, 24, requester and ROM address width.
- DATA_W, 32, ROM data width.
- MAX_WAIT, 4, maximum number of consecutive cycles port B may be denied while requesting before it takes priority. Legal range is 0..15; 0 means B always has priority.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- A_REQ  in  1  fetch request; held until granted.
- A_ADDR  in  ADDR_W  fetch word address.
- A_GNT  out  1  fetch request accepted this cycle (combinational).
- A_RVALID  out  1  A_RDATA is fresh this cycle.
- A_RDATA  out  DATA_W  fetch data; holds the last value between responses.
- B_REQ, B_ADDR, B_GNT, B_RVALID, B_RDATA: same as the A_ signals, for port B.
- ROM_ADDR  out  ADDR_W  address to the ROM.
- ROM_CS  out  1  ROM read strobe.
- ROM_DOUT  in  DATA_W  ROM registered output, valid the cycle after ROM_CS.

## Operation
- Grant rule, evaluated combinationally each cycle:
  - b_pri = (wait_cnt >= MAX_WAIT).
  - B_GNT = B_REQ & (!A_REQ | b_pri).
  - A_GNT = A_REQ & !B_GNT.
  - At most one grant per cycle.
- ROM drive:
  - ROM_CS = A_GNT | B_GNT.
  - ROM_ADDR = B_GNT ? B_ADDR : A_ADDR (A_ADDR when idle).
- Wait counter, 4 bits:
  - Cleared on reset and on B_GNT.
  - Incremented when B_REQ & !B_GNT, saturating at MAX_WAIT.
  - Held when B is not requesting.
- Response tracker (resp_sel register), encodings NONE/A/B:
  - Loads A if A_GNT, B if B_GNT, otherwise NONE.
  - X_RVALID = (resp_sel == X).
- Read data:
  - When X_RVALID is high, X_RDATA = ROM_DOUT, and hold_X captures ROM_DOUT on that edge.
  - Otherwise X_RDATA = hold_X. A port's data is never corrupted by the other port's accesses.
- No cancellation: a granted access always returns exactly one RVALID.

## Timing
- Grant is in the same cycle as REQ when the port wins.
- Data latency is 1 cycle: RVALID is asserted in the cycle after GNT.
- Throughput: one access per cycle in total, back-to-back in either port.
- Port B worst-case wait under continuous A_REQ: B_GNT in the (MAX_WAIT+1)-th cycle of B_REQ.
- Reset (asynchronous assert, synchronous release) clears:
  - resp_sel = NONE, wait_cnt = 0, hold_A = hold_B = 0.
  - So A_RVALID = B_RVALID = 0 and A_RDATA = B_RDATA = 0.
- While RST_N is low, A_GNT, B_GNT and ROM_CS are forced to 0 and ROM_ADDR is 0.
- Reset asserted in the cycle after a grant: that response is dropped (RVALID stays 0). Requesters must reissue after reset.
- Simultaneous events:
  - A_REQ and B_REQ together with wait_cnt < MAX_WAIT: A wins and the count increments.
  - Same with wait_cnt == MAX_WAIT: B wins and the count clears.
- A requester dropping REQ without a grant is legal; no state is kept for it.

## Structure
- Shared include/package irom_arb_pkg holds:
  - RESP_NONE = 2'd0, RESP_A = 2'd1, RESP_B = 2'd2.
  - The default ADDR_W and DATA_W constants, shared with irom.
- Single module, no sub-modules. The per-port hold/mux logic is small enough to stay inline.
- The bench instantiates irom_arb with irom behind it, preloaded from a hex file where word[i] = 32'hC0DE_0000 + i.

## Test plan
- Reset: hold RST_N low with A_REQ=1 -> A_GNT=0, ROM_CS=0, A_RDATA=0, B_RDATA=0. Release reset -> A_GNT=1 in the same cycle.
- Single fetch: A_REQ with A_ADDR=5 for one cycle -> A_GNT=1, then the next cycle A_RVALID=1 and A_RDATA=32'hC0DE0005. The value holds after A_RVALID drops.
- Back-to-back fetch: A_ADDR=0,1,2,3 on consecutive cycles -> A_RVALID high for 4 cycles with data ...0000 through ...0003, no bubbles.
- Starvation bound: A_REQ held continuously, B_REQ with B_ADDR=9 from cycle 0, MAX_WAIT=4 -> B_GNT in cycle 4, B_RDATA=32'hC0DE0009 in cycle 5. A_GNT is low only in cycle 4.
- Isolation: A reads addr 7, then B reads addr 8 -> A_RDATA stays 32'hC0DE0007 while B_RDATA becomes 32'hC0DE0008.
- Mid-access reset: B_GNT at addr 3, RST_N low in the next cycle -> B_RVALID=0, B_RDATA=0, wait_cnt=0.
